cocotb_template_dut: RTL and testbench

Reference stream-buffer block for the cocotb template flow. Data words enter on a valid/ready slave port, pass through a synchronous FIFO unchanged, and leave on a valid/ready master port. Built-in probe counters and status flags are read by the cocotb environment for checking. It is a self-contained leaf block clocked by a single clock.

---
 rtl/cocotb_template_dut.sv | 150 +++++++++++++++
 tb/tb_cocotb_template_dut.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cocotb_template_dut.sv
// -----------------------------------------------------------------------------
// cocotb_template_dut
//
// Stream buffer. Words accepted on a valid/ready slave port are stored in a
// synchronous FIFO and delivered unchanged, in order, on a valid/ready master
// port. Probe counters and status flags expose occupancy and traffic totals.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset (synchronous release expected)
//   clear      synchronous flush of FIFO contents and counters
//   s_valid    input word valid
//   s_ready    block can accept a word (= !full)
//   s_data     input word
//   m_valid    output word valid (= !empty)
//   m_ready    downstream accepts the output word
//   m_data     word at the read pointer, 0 while empty
//   level      number of stored words
//   full       level == DEPTH
//   empty      level == 0
//   in_count   accepted input words, wraps modulo 2^CNT_W
//   out_count  delivered output words, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module cocotb_template_dut #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         in_count,
  output logic [CNT_W-1:0]         out_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg,    wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg,    rd_ptr_next;
  logic [LVL_W-1:0]  level_reg,     level_next;
  logic [CNT_W-1:0]  in_count_reg,  in_count_next;
  logic [CNT_W-1:0]  out_count_reg, out_count_next;

  logic full_flag;
  logic empty_flag;
  logic push;
  logic pop;

  // ---------------------------------------------------------------------------
  // Status and handshakes
  // ---------------------------------------------------------------------------
  // Flags derive only from the registered level, so s_ready never depends on
  // m_ready: a full FIFO refuses a push even when a pop happens that cycle.
  assign full_flag  = (level_reg == LVL_W'(DEPTH));
  assign empty_flag = (level_reg == '0);

  assign s_ready = ~full_flag;
  assign m_valid = ~empty_flag;
  assign full    = full_flag;
  assign empty   = empty_flag;
  assign level   = level_reg;

  assign in_count  = in_count_reg;
  assign out_count = out_count_reg;

  // clear wins over both handshakes; s_ready is still shown during the clear
  // cycle but the transfer is not recorded.
  assign push = s_valid & ~full_flag  & ~clear;
  assign pop  = m_ready & ~empty_flag & ~clear;

  // Output word is forced to zero while empty so the port never shows
  // uninitialised storage after reset or a flush.
  assign m_data = empty_flag ? '0 : mem_reg[rd_ptr_reg];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    level_next     = level_reg;
    in_count_next  = in_count_reg;
    out_count_next = out_count_reg;

    if (clear) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      level_next     = '0;
      in_count_next  = '0;
      out_count_next = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) begin
        wr_ptr_next   = wr_ptr_reg + PTR_W'(1);
        in_count_next = in_count_reg + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_next    = rd_ptr_reg + PTR_W'(1);
        out_count_next = out_count_reg + CNT_W'(1);
      end
      unique case ({push, pop})
        2'b10:   level_next = level_reg + LVL_W'(1);
        2'b01:   level_next = level_reg - LVL_W'(1);
        default: level_next = level_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      in_count_reg  <= '0;
      out_count_reg <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      in_count_reg  <= in_count_next;
      out_count_reg <= out_count_next;
    end
  end

  // Storage needs no reset: a slot is only ever read after it was written,
  // and m_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= s_data;
    end
  end

endmodule

// File: tb/tb_cocotb_template_dut.sv
module tb_cocotb_template_dut;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 32;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [3:0]        level;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  in_count;
  logic [CNT_W-1:0]  out_count;

  cocotb_template_dut #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level), .full(full), .empty(empty),
    .in_count(in_count), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e_mv, input logic [15:0] e_md,
                           input logic [3:0] e_lvl, input logic e_full, input logic e_empty,
                           input logic e_sr, input logic [31:0] e_in, input logic [31:0] e_out);
    check({tag, ".m_valid"},   64'(m_valid),   64'(e_mv));
    check({tag, ".m_data"},    64'(m_data),    64'(e_md));
    check({tag, ".level"},     64'(level),     64'(e_lvl));
    check({tag, ".full"},      64'(full),      64'(e_full));
    check({tag, ".empty"},     64'(empty),     64'(e_empty));
    check({tag, ".s_ready"},   64'(s_ready),   64'(e_sr));
    check({tag, ".in_count"},  64'(in_count),  64'(e_in));
    check({tag, ".out_count"}, 64'(out_count), 64'(e_out));
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: inputs for one cycle, expected state after the edge
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        sv;
    logic [15:0] d;
    logic        mr;
    logic        clr;
    logic [15:0] e_md;
    logic [3:0]  e_lvl;
    logic [31:0] e_in;
    logic [31:0] e_out;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic sv, input logic [15:0] d, input logic mr, input logic clr,
                     input logic [15:0] e_md, input int e_lvl, input int e_in, input int e_out);
    vec_t v;
    v.sv = sv; v.d = d; v.mr = mr; v.clr = clr;
    v.e_md = e_md; v.e_lvl = 4'(e_lvl); v.e_in = 32'(e_in); v.e_out = 32'(e_out);
    vt.push_back(v);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model for the hand-written multi-cycle sequences
  // ---------------------------------------------------------------------------
  logic [15:0] mq[$];
  int m_in  = 0;
  int m_out = 0;

  task automatic model_cycle(input string tag, input logic sv, input logic [15:0] d,
                             input logic mr, input logic clr);
    bit do_push, do_pop;
    logic [15:0] head;
    do_push = sv && (mq.size() < DEPTH) && !clr;
    do_pop  = mr && (mq.size() > 0) && !clr;
    s_valid = sv; s_data = d; m_ready = mr; clear = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      mq.delete(); m_in = 0; m_out = 0;
    end else begin
      if (do_pop)  begin void'(mq.pop_front()); m_out++; end
      if (do_push) begin mq.push_back(d); m_in++; end
    end
    head = (mq.size() > 0) ? mq[0] : 16'h0000;
    check_all(tag, mq.size() > 0, head, 4'(mq.size()), mq.size() == DEPTH,
              mq.size() == 0, mq.size() != DEPTH, 32'(m_in), 32'(m_out));
  endtask

  initial begin
    int stream_max_level;
    logic [15:0] next_word;

    rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

    // Single word, then pop
    add(1, 16'hA5A5, 0, 0, 16'hA5A5, 1, 1, 0);
    add(0, 16'h0000, 1, 0, 16'h0000, 0, 1, 1);
    // Clear from idle zeroes the counters
    add(0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0);
    // Fill to full: head stays at 0x0001
    for (int k = 1; k <= 8; k++) add(1, 16'(k), 0, 0, 16'h0001, k, k, 0);
    // 9th word held on s_valid is refused
    add(1, 16'h0009, 0, 0, 16'h0001, 8, 8, 0);
    add(1, 16'h0009, 0, 0, 16'h0001, 8, 8, 0);
    // Pop while full: push still refused in the same cycle
    add(1, 16'h0009, 1, 0, 16'h0002, 7, 8, 1);
    // Drain the rest in order 0x0003..0x0008
    for (int j = 1; j <= 7; j++) add(0, 16'h0000, 1, 0, (j < 7) ? 16'(j + 2) : 16'h0000, 7 - j, 8, 1 + j);
    // Simultaneous push and pop keeps level
    add(1, 16'h1111, 0, 0, 16'h1111, 1, 9, 8);
    add(1, 16'h2222, 1, 0, 16'h2222, 1, 10, 9);
    add(1, 16'h3333, 0, 0, 16'h2222, 2, 11, 9);
    add(1, 16'h4444, 0, 0, 16'h2222, 3, 12, 9);
    add(1, 16'h5555, 0, 0, 16'h2222, 4, 13, 9);
    // Clear at level 4 with push and pop requested: clear wins
    add(1, 16'h6666, 1, 1, 16'h0000, 0, 0, 0);
    // Empty: s_data ignored without s_valid, m_ready ignored without m_valid
    add(0, 16'hDEAD, 1, 0, 16'h0000, 0, 0, 0);
    add(1, 16'h7777, 0, 0, 16'h7777, 1, 1, 0);

    // Reset for 5 cycles, release mid-cycle
    repeat (5) @(posedge clk);
    #1;
    check_all("reset", 0, 16'h0000, 0, 0, 1, 1, 0, 0);
    rst_n = 1'b1;
    #2;
    check_all("idle", 0, 16'h0000, 0, 0, 1, 1, 0, 0);

    foreach (vt[i]) begin
      s_valid = vt[i].sv; s_data = vt[i].d; m_ready = vt[i].mr; clear = vt[i].clr;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vt[i].e_lvl != 0, vt[i].e_md, vt[i].e_lvl,
                vt[i].e_lvl == 8, vt[i].e_lvl == 0, vt[i].e_lvl != 8, vt[i].e_in, vt[i].e_out);
      $display("vec %0d: sv=%0b d=%h mr=%0b clr=%0b -> level=%0d m_data=%h in=%0d out=%0d",
               i, vt[i].sv, vt[i].d, vt[i].mr, vt[i].clr, level, m_data, in_count, out_count);
    end

    // Sync the model with the table's final state, drain, then clear counters
    mq.delete(); mq.push_back(16'h7777); m_in = 1; m_out = 0;
    model_cycle("drain7777", 0, 16'h0000, 1, 0);
    model_cycle("preclear", 0, 16'h0000, 0, 1);

    // Streaming: 100 words with s_valid and m_ready held high
    stream_max_level = 0;
    for (int i = 0; i < 100; i++) begin
      model_cycle("stream", 1, 16'(16'hC000 + i), 1, 0);
      if (int'(level) > stream_max_level) stream_max_level = int'(level);
    end
    model_cycle("stream_tail", 0, 16'h0000, 1, 0);
    check("stream.max_level_le1", 64'(stream_max_level <= 1), 64'(1));
    check("stream.in_count", 64'(in_count), 64'd100);
    check("stream.out_count", 64'(out_count), 64'd100);
    $display("stream: 100 words, max level %0d, in=%0d out=%0d", stream_max_level, in_count, out_count);

    // Pointer wrap: 3 rounds of fill-to-full / drain-5, then drain all
    model_cycle("wrap_clear", 0, 16'h0000, 0, 1);
    next_word = 16'h0100;
    for (int r = 0; r < 3; r++) begin
      while (mq.size() < DEPTH) begin
        model_cycle("wrap_fill", 1, next_word, 0, 0);
        next_word++;
      end
      for (int j = 0; j < 5; j++) model_cycle("wrap_drain5", 0, 16'h0000, 1, 0);
      $display("wrap round %0d: level=%0d in=%0d out=%0d", r, level, in_count, out_count);
    end
    for (int j = 0; j < 3; j++) model_cycle("wrap_drain", 0, 16'h0000, 1, 0);
    check("wrap.level", 64'(level), 64'd0);
    check("wrap.in_count", 64'(in_count), 64'd18);
    check("wrap.out_count", 64'(out_count), 64'd18);

    // Asynchronous reset mid-cycle at level 3
    for (int j = 0; j < 3; j++) model_cycle("pre_rst", 1, 16'(16'hE000 + j), 0, 0);
    s_valid = 1'b0; m_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 16'h0000, 0, 0, 1, 1, 0, 0);
    $display("async reset: level=%0d m_valid=%0b in=%0d out=%0d", level, m_valid, in_count, out_count);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    mq.delete(); m_in = 0; m_out = 0;
    model_cycle("post_rst_push", 1, 16'hBEEF, 0, 0);
    model_cycle("post_rst_pop", 0, 16'h0000, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
